// File: rtl/axi_spi_regs.sv
// -----------------------------------------------------------------------------
// axi_spi_regs
//
// AXI4-Lite register file and transfer sequencer that sits in front of the SPI
// master engine. The CPU programs configuration, timing and the TX word, then
// writes GO. The sequencer raises start until the engine reports busy. When
// busy falls, it captures miso_data into RXDATA and sets rx_valid.
//
// Register map (byte offsets, only addr[4:2] decoded):
//   0x00 CTRL   RW  [1:0] spi_mode, [3:2] sck_speed, [5:4] word_len, [8] GO (pulse, reads 0)
//   0x04 TIMING RW  [7:0] t_IFG, [15:8] t_CS_SCK, [23:16] t_SCK_CS
//   0x08 TXDATA RW  TX word
//   0x0C RXDATA RO  last captured word; reading it clears rx_valid
//   0x10 STATUS     [0] busy, [1] rx_valid, [2] overrun (W1C), [3] go_drop (W1C)
//   0x18 IRQEN  RW  [0] done_en, [1] err_en   (only with AXI_SPI_IRQ_EN)
//   all other offsets: read 0 / write ignored, SLVERR
//
// Optional feature macro: AXI_SPI_IRQ_EN (adds IRQEN and a registered irq;
// without it irq is tied 0 and 0x18 is unmapped).
//
// Ports:
//   GCLK, RST                 clock and asynchronous active-high reset
//   s_aw*, s_w*, s_b*         AXI4-Lite write address / data / response
//   s_ar*, s_r*               AXI4-Lite read address / data
//   spi_mode, sck_speed, word_len, t_IFG, t_CS_SCK, t_SCK_CS, mosi_data
//                             engine configuration, straight from registers
//   start                     engine start request (registered)
//   busy, miso_data           engine status and received word
//   irq                       interrupt request
// -----------------------------------------------------------------------------
module axi_spi_regs #(
   parameter int ADDR_W = 5
) (
   input  logic              GCLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [1:0]        spi_mode,
   output logic [1:0]        sck_speed,
   output logic [1:0]        word_len,
   output logic [7:0]        t_IFG,
   output logic [7:0]        t_CS_SCK,
   output logic [7:0]        t_SCK_CS,
   output logic [31:0]       mosi_data,
   output logic              start,
   input  logic              busy,
   input  logic [31:0]       miso_data,
   output logic              irq
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      R_CTRL   = 3'd0,
      R_TIMING = 3'd1,
      R_TXDATA = 3'd2,
      R_RXDATA = 3'd3,
      R_STATUS = 3'd4,
      R_RSVD5  = 3'd5,
      R_IRQEN  = 3'd6,
      R_RSVD7  = 3'd7
   } reg_sel_e;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} seq_state_e;

   // ---------------------------------------------------------------- state
   logic        aw_held_q, aw_held_d;
   reg_sel_e    aw_sel_q, aw_sel_d;
   logic        w_held_q, w_held_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        awready_q, awready_d;
   logic        wready_q, wready_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [5:0]  ctrl_cfg_q, ctrl_cfg_d;
   logic [23:0] timing_q, timing_d;
   logic [31:0] txdata_q, txdata_d;
   logic [31:0] rxdata_q, rxdata_d;
   logic        rx_valid_q, rx_valid_d;
   logic        overrun_q, overrun_d;
   logic        go_drop_q, go_drop_d;
   seq_state_e  state_q;
   logic        start_q;
   logic        busy_q;

   // Only addr[4:2] select a register; the rest of the address is don't-care.
   logic        unused_addr;
   assign unused_addr = ^{s_awaddr, s_araddr};

   // ---------------------------------------------------------------- events
   logic     aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic     do_write, seq_idle, complete;
   logic     go_bit, go_accept, go_reject;
   reg_sel_e ar_sel;
   logic     rx_read;

   assign aw_hs     = s_awvalid & awready_q;
   assign w_hs      = s_wvalid  & wready_q;
   assign ar_hs     = s_arvalid & arready_q;
   assign b_hs      = bvalid_q  & s_bready;
   assign r_hs      = rvalid_q  & s_rready;
   // The register update fires in the cycle both halves of the write are held.
   assign do_write  = aw_held_q & w_held_q;
   assign seq_idle  = (state_q == S_IDLE);
   assign complete  = (state_q == S_WAIT) & busy_q & ~busy;
   assign go_bit    = do_write & (aw_sel_q == R_CTRL) & wstrb_q[1] & wdata_q[8];
   assign go_accept = go_bit & seq_idle;
   assign go_reject = go_bit & ~seq_idle;
   assign ar_sel    = reg_sel_e'(s_araddr[4:2]);
   assign rx_read   = ar_hs & (ar_sel == R_RXDATA);

`ifdef AXI_SPI_IRQ_EN
   logic [1:0] irqen_q, irqen_d;
   logic       irq_q, irq_d;
`endif

   // ---------------------------------------------------------------- write decode
   logic       wr_ctrl, wr_timing, wr_tx, wr_status, wr_irqen;
   logic [1:0] wr_resp;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the case statement can leave a latch behind.
      wr_ctrl   = 1'b0;
      wr_timing = 1'b0;
      wr_tx     = 1'b0;
      wr_status = 1'b0;
      wr_irqen  = 1'b0;
      wr_resp   = RESP_OKAY;
      case (aw_sel_q)
         // GO lives in byte 1 and is handled by the sequencer; only a write
         // touching the config byte is refused mid-transfer.
         R_CTRL: begin
            if (wstrb_q[0]) begin
               if (seq_idle) wr_ctrl = 1'b1;
               else          wr_resp = RESP_SLVERR;
            end
         end
         R_TIMING: begin
            if (seq_idle) wr_timing = 1'b1;
            else          wr_resp   = RESP_SLVERR;
         end
         R_TXDATA: begin
            if (seq_idle) wr_tx   = 1'b1;
            else          wr_resp = RESP_SLVERR;
         end
         R_RXDATA: wr_resp   = RESP_OKAY;
         R_STATUS: wr_status = 1'b1;
`ifdef AXI_SPI_IRQ_EN
         R_IRQEN:  wr_irqen  = 1'b1;
`endif
         default:  wr_resp   = RESP_SLVERR;
      endcase
   end

   // ---------------------------------------------------------------- read mux
   logic [31:0] rd_data;
   logic [1:0]  rd_resp;

   always_comb begin
      rd_data = 32'h0;
      rd_resp = RESP_OKAY;
      case (ar_sel)
         R_CTRL:   rd_data = {26'h0, ctrl_cfg_q};
         R_TIMING: rd_data = {8'h0, timing_q};
         R_TXDATA: rd_data = txdata_q;
         R_RXDATA: rd_data = rxdata_q;
         R_STATUS: rd_data = {28'h0, go_drop_q, overrun_q, rx_valid_q, ~seq_idle};
`ifdef AXI_SPI_IRQ_EN
         R_IRQEN:  rd_data = {30'h0, irqen_q};
`endif
         default:  rd_resp = RESP_SLVERR;
      endcase
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      aw_held_d  = aw_held_q;
      aw_sel_d   = aw_sel_q;
      w_held_d   = w_held_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      ctrl_cfg_d = ctrl_cfg_q;
      timing_d   = timing_q;
      txdata_d   = txdata_q;
      rxdata_d   = rxdata_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
      go_drop_d  = go_drop_q;
`ifdef AXI_SPI_IRQ_EN
      irqen_d    = irqen_q;
`endif

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_sel_d  = reg_sel_e'(s_awaddr[4:2]);
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_wdata;
         wstrb_d  = s_wstrb;
      end

      if (do_write) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_resp;
         if (wr_ctrl) ctrl_cfg_d = wdata_q[5:0];
         for (int i = 0; i < 3; i++) begin
            if (wr_timing && wstrb_q[i]) timing_d[8*i +: 8] = wdata_q[8*i +: 8];
         end
         for (int i = 0; i < 4; i++) begin
            if (wr_tx && wstrb_q[i]) txdata_d[8*i +: 8] = wdata_q[8*i +: 8];
         end
         // W1C: clear first, the set terms below override on a collision.
         if (wr_status && wstrb_q[0]) begin
            if (wdata_q[2]) overrun_d = 1'b0;
            if (wdata_q[3]) go_drop_d = 1'b0;
         end
`ifdef AXI_SPI_IRQ_EN
         if (wr_irqen && wstrb_q[0]) irqen_d = wdata_q[1:0];
`endif
      end else if (b_hs) begin
         bvalid_d = 1'b0;
      end

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_data;
         rresp_d  = rd_resp;
      end else if (r_hs) begin
         rvalid_d = 1'b0;
      end

      // A completion in the same cycle as an RXDATA read keeps rx_valid set.
      if (rx_read)   rx_valid_d = 1'b0;
      if (complete) begin
         rxdata_d   = miso_data;
         rx_valid_d = 1'b1;
         if (rx_valid_q) overrun_d = 1'b1;
      end
      if (go_reject) go_drop_d = 1'b1;
   end

   // Readies are registered so they stay low through reset and drop the cycle
   // after a beat is taken.
   assign awready_d = ~aw_held_d & ~bvalid_d;
   assign wready_d  = ~w_held_d  & ~bvalid_d;
   assign arready_d = ~rvalid_d;

`ifdef AXI_SPI_IRQ_EN
   assign irq_d = (irqen_q[0] & rx_valid_q) | (irqen_q[1] & (overrun_q | go_drop_q));
`endif

   // ---------------------------------------------------------------- registers
   // NOTE: every register here, including the data words, is reset so the
   // CPU reads a defined 0 after RST rather than power-up garbage.
   always_ff @(posedge GCLK or posedge RST) begin
      if (RST) begin
         aw_held_q  <= 1'b0;
         aw_sel_q   <= R_CTRL;
         w_held_q   <= 1'b0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'h0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'h0;
         rresp_q    <= RESP_OKAY;
         ctrl_cfg_q <= 6'h0;
         timing_q   <= 24'h0;
         txdata_q   <= 32'h0;
         rxdata_q   <= 32'h0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         go_drop_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of every other register, independent of order.
         aw_held_q  <= aw_held_d;
         aw_sel_q   <= aw_sel_d;
         w_held_q   <= w_held_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         ctrl_cfg_q <= ctrl_cfg_d;
         timing_q   <= timing_d;
         txdata_q   <= txdata_d;
         rxdata_q   <= rxdata_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         go_drop_q  <= go_drop_d;
      end
   end

`ifdef AXI_SPI_IRQ_EN
   always_ff @(posedge GCLK or posedge RST) begin
      if (RST) begin
         irqen_q <= 2'b00;
         irq_q   <= 1'b0;
      end else begin
         irqen_q <= irqen_d;
         irq_q   <= irq_d;
      end
   end
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   // ---------------------------------------------------------------- sequencer
   // start is high exactly while in REQ and falls on the edge busy is sampled.
   always_ff @(posedge GCLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= busy;
         case (state_q)
            S_IDLE: begin
               if (go_accept) begin
                  state_q <= S_REQ;
                  start_q <= 1'b1;
               end
            end
            S_REQ: begin
               if (busy) begin
                  state_q <= S_WAIT;
                  start_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (busy_q && !busy) state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               start_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign s_awready = awready_q;
   assign s_wready  = wready_q;
   assign s_bvalid  = bvalid_q;
   assign s_bresp   = bresp_q;
   assign s_arready = arready_q;
   assign s_rvalid  = rvalid_q;
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;
   assign spi_mode  = ctrl_cfg_q[1:0];
   assign sck_speed = ctrl_cfg_q[3:2];
   assign word_len  = ctrl_cfg_q[5:4];
   assign t_IFG     = timing_q[7:0];
   assign t_CS_SCK  = timing_q[15:8];
   assign t_SCK_CS  = timing_q[23:16];
   assign mosi_data = txdata_q;
   assign start     = start_q;

endmodule
